// File: rtl/if_pc_gen.sv
// Fetch-address generator: issues block-aligned ICache requests, applies
// exception/EX/predictor redirects and parks backend redirects seen during a stall.
module if_pc_gen #(
  parameter int              WORD        = 32,
  parameter int              FETCH_WIDTH = 2,
  parameter logic [WORD-1:0] RESET_PC    = 'h1c000000,
  parameter int              N_STALL     = 3,
  parameter int              EPOCH_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_STALL-1:0]     stall_vec,
  input  logic                   pre_branch,
  input  logic [WORD-1:0]        pre_pc,
  input  logic                   ex_branch,
  input  logic [WORD-1:0]        ex_pc,
  input  logic                   exc_redirect,
  input  logic [WORD-1:0]        exc_pc,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [WORD-1:0]        pc_out,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic [EPOCH_W-1:0]     epoch,
  output logic                   redirect_pending
);

  localparam int              OFF   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 0;
  localparam int              BW    = WORD - OFF - 2;
  localparam logic [WORD-1:0] ALIGN = {{(WORD-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t              state_q;
  logic [WORD-1:0]     pc_q;
  logic [WORD-1:0]     pending_pc_q;
  logic                valid_q;
  logic [EPOCH_W-1:0]  epoch_q;

  logic                stall;
  logic                bred_vld;
  logic [WORD-1:0]     bred_pc;
  logic                fire;
  logic [WORD-1:0]     seq_pc;

  assign stall    = |stall_vec;
  assign bred_vld = exc_redirect | ex_branch;
  assign bred_pc  = (exc_redirect ? exc_pc : ex_pc) & ALIGN;
  assign fire     = valid_q & fetch_ready & ~stall;
  assign seq_pc   = {pc_q[WORD-1:OFF+2] + BW'(1), {(OFF+2){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      valid_q      <= 1'b0;
      epoch_q      <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (bred_vld) begin
            epoch_q <= epoch_q + EPOCH_W'(1);
            if (stall) begin
              pending_pc_q <= bred_pc;
              state_q      <= HOLD;
              valid_q      <= 1'b0;
            end else begin
              pc_q <= bred_pc;
            end
          end else if (fire) begin
            pc_q <= pre_branch ? (pre_pc & ALIGN) : seq_pc;
          end
        end
        HOLD: begin
          // A redirect landing in the release cycle wins over the parked one.
          if (bred_vld) begin
            epoch_q      <= epoch_q + EPOCH_W'(1);
            pending_pc_q <= bred_pc;
          end
          if (!stall) begin
            pc_q    <= bred_vld ? bred_pc : pending_pc_q;
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid      = valid_q;
  assign pc_out           = pc_q;
  assign epoch            = epoch_q;
  assign redirect_pending = (state_q == HOLD);

  // Slots before the entry slot of an unaligned target are not part of this fetch.
  if (FETCH_WIDTH == 1) begin : g_single
    assign fetch_mask = '1;
  end else begin : g_multi
    logic [OFF-1:0] slot;
    assign slot = pc_q[OFF+1:2];
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
      assign fetch_mask[i] = (OFF'(i) >= slot);
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: hand-computed vector table, async-reset sequence, then
// randomized traffic against a block-arithmetic reference model.
module tb_if_pc_gen;

  localparam int FW = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  stall_vec = '0;
  logic        pre_branch = 1'b0;
  logic [31:0] pre_pc = '0;
  logic        ex_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        exc_redirect = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        fetch_ready = 1'b1;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [1:0]  fetch_mask;
  logic [1:0]  epoch;
  logic        redirect_pending;

  if_pc_gen #(.WORD(32), .FETCH_WIDTH(FW), .RESET_PC(32'h1c000000), .N_STALL(3), .EPOCH_W(2)) dut (
    .clk(clk), .rst(rst), .stall_vec(stall_vec),
    .pre_branch(pre_branch), .pre_pc(pre_pc),
    .ex_branch(ex_branch), .ex_pc(ex_pc),
    .exc_redirect(exc_redirect), .exc_pc(exc_pc),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc_out(pc_out),
    .fetch_mask(fetch_mask), .epoch(epoch), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  stall;
    logic        pre;
    logic [31:0] ppc;
    logic        ex;
    logic [31:0] epc;
    logic        exc;
    logic [31:0] xpc;
    logic        rdy;
    logic        e_v;
    logic [31:0] e_pc;
    logic [1:0]  e_mask;
    logic [1:0]  e_ep;
    logic        e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] s, logic p, logic [31:0] ppc, logic e, logic [31:0] epc,
                              logic x, logic [31:0] xpc, logic r, logic ev, logic [31:0] epc_o,
                              logic [1:0] em, logic [1:0] ee, logic ep);
    vec_t t;
    t.stall = s; t.pre = p; t.ppc = ppc; t.ex = e; t.epc = epc; t.exc = x; t.xpc = xpc; t.rdy = r;
    t.e_v = ev; t.e_pc = epc_o; t.e_mask = em; t.e_ep = ee; t.e_pend = ep;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [1:0] em, input logic [1:0] ee, input logic ep);
    cmp({tag, ".valid"}, 32'(fetch_valid), 32'(ev));
    cmp({tag, ".pc"}, pc_out, epc);
    cmp({tag, ".mask"}, 32'(fetch_mask), 32'(em));
    cmp({tag, ".epoch"}, 32'(epoch), 32'(ee));
    cmp({tag, ".pending"}, 32'(redirect_pending), 32'(ep));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_vec = '0; pre_branch = 1'b0; pre_pc = '0; ex_branch = 1'b0; ex_pc = '0;
    exc_redirect = 1'b0; exc_pc = '0; fetch_ready = 1'b1;
  endtask

  // Reference model: addresses as block number * block bytes.
  int          m_mode;
  logic [31:0] m_pc, m_pend;
  logic [1:0]  m_ep;

  function automatic logic [31:0] m_next_block(input logic [31:0] pc);
    logic [63:0] t;
    t = ((64'(pc) / (FW * 4)) + 64'd1) * (FW * 4);
    return t[31:0];
  endfunction

  function automatic logic [1:0] m_mask(input logic [31:0] pc);
    logic [1:0] m;
    int entry;
    entry = int'((pc >> 2) % FW);
    for (int i = 0; i < FW; i++) m[i] = (i >= entry);
    return m;
  endfunction

  task automatic model_step();
    logic        stl, redir;
    logic [31:0] tgt;
    stl   = (stall_vec != 3'b000);
    redir = ex_branch | exc_redirect;
    tgt   = (exc_redirect ? exc_pc : ex_pc) & 32'hFFFF_FFFC;
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redir) begin
        m_ep = m_ep + 2'd1;
        if (stl) begin m_pend = tgt; m_mode = M_HOLD; end
        else m_pc = tgt;
      end else if (!stl && fetch_ready) begin
        m_pc = pre_branch ? (pre_pc & 32'hFFFF_FFFC) : m_next_block(m_pc);
      end
    end else begin
      if (redir) begin m_ep = m_ep + 2'd1; m_pend = tgt; end
      if (!stl) begin m_pc = m_pend; m_mode = M_RUN; end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | (r & 32'hF);
    return 32'h1c00_0000 + (r & 32'hFFFF);
  endfunction

  initial begin
    // Stimulus table: inputs for one cycle, outputs expected after that edge.
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000000,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000008,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000010,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000106,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000104,2'b10,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000108,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b001,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000108,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b001,1'b0,32'h0,1'b1,32'h1c000200,1'b0,32'h0,1'b1, 1'b0,32'h1c000108,2'b11,2'd1,1'b1));
    tbl.push_back(mk(3'b001,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b0,32'h1c000108,2'b11,2'd1,1'b1));
    tbl.push_back(mk(3'b001,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b0,32'h1c000108,2'b11,2'd1,1'b1));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000200,2'b11,2'd1,1'b0));
    tbl.push_back(mk(3'b010,1'b1,32'h1c000500,1'b1,32'h1c000300,1'b1,32'h1c008000,1'b1, 1'b0,32'h1c000200,2'b11,2'd2,1'b1));
    tbl.push_back(mk(3'b010,1'b0,32'h0,1'b1,32'h1c000400,1'b0,32'h0,1'b1, 1'b0,32'h1c000200,2'b11,2'd3,1'b1));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000400,2'b11,2'd3,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000500,1'b1,32'h1c000300,1'b1,32'h1c008000,1'b1, 1'b1,32'h1c008000,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000600,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h1c008000,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000600,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h1c008000,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000600,1'b0,32'h0,1'b0,32'h0,1'b0, 1'b1,32'h1c008000,2'b11,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b1,32'h1c00000b,1'b0,32'h0,1'b1, 1'b1,32'h1c000008,2'b11,2'd1,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b1,32'hfffffff9,1'b0,32'h0,1'b1, 1'b1,32'hfffffff8,2'b11,2'd2,1'b0));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h00000000,2'b11,2'd2,1'b0));
    tbl.push_back(mk(3'b100,1'b0,32'h0,1'b1,32'h1c000010,1'b0,32'h0,1'b1, 1'b0,32'h00000000,2'b11,2'd3,1'b1));
    tbl.push_back(mk(3'b000,1'b0,32'h0,1'b0,32'h0,1'b1,32'h1c000a04,1'b1, 1'b1,32'h1c000a04,2'b10,2'd0,1'b0));
    tbl.push_back(mk(3'b000,1'b1,32'h1c000a00,1'b0,32'h0,1'b0,32'h0,1'b1, 1'b1,32'h1c000a00,2'b11,2'd0,1'b0));

    idle_inputs();
    tick();
    tick();
    check_all("reset", 1'b0, 32'h1c000000, 2'b11, 2'd0, 1'b0);
    rst = 1'b0;
    #1;
    check_all("boot", 1'b0, 32'h1c000000, 2'b11, 2'd0, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      stall_vec = tbl[k].stall; pre_branch = tbl[k].pre; pre_pc = tbl[k].ppc;
      ex_branch = tbl[k].ex; ex_pc = tbl[k].epc; exc_redirect = tbl[k].exc;
      exc_pc = tbl[k].xpc; fetch_ready = tbl[k].rdy;
      tick();
      check_all($sformatf("row%0d", k), tbl[k].e_v, tbl[k].e_pc, tbl[k].e_mask, tbl[k].e_ep, tbl[k].e_pend);
    end

    // Async reset while parked in HOLD, then BOOT must ignore redirects.
    idle_inputs();
    stall_vec = 3'b001; ex_branch = 1'b1; ex_pc = 32'h1c000c00;
    tick();
    check_all("enter_hold", 1'b0, 32'h1c000a00, 2'b11, 2'd1, 1'b1);
    ex_branch = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 32'h1c000000, 2'b11, 2'd0, 1'b0);
    tick();
    check_all("rst_held", 1'b0, 32'h1c000000, 2'b11, 2'd0, 1'b0);
    rst = 1'b0;
    stall_vec = 3'b000; ex_branch = 1'b1; ex_pc = 32'h1c000700;
    pre_branch = 1'b1; pre_pc = 32'h1c000900;
    tick();
    check_all("boot_ignore", 1'b1, 32'h1c000000, 2'b11, 2'd0, 1'b0);
    idle_inputs();
    tick();
    check_all("boot_seq", 1'b1, 32'h1c000008, 2'b11, 2'd0, 1'b0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_mode = M_BOOT; m_pc = 32'h1c000000; m_pend = '0; m_ep = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 3; b++) stall_vec[b] = ($urandom_range(0, 5) == 0);
      pre_branch   = ($urandom_range(0, 3) == 0);
      pre_pc       = rand_pc();
      ex_branch    = ($urandom_range(0, 9) == 0);
      ex_pc        = rand_pc();
      exc_redirect = ($urandom_range(0, 15) == 0);
      exc_pc       = rand_pc();
      fetch_ready  = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      check_all("rnd", (m_mode == M_RUN), m_pc, m_mask(m_pc), m_ep, (m_mode == M_HOLD));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
